// File: rtl/sensor_frame_checker.sv
// Frame checker for the emulated-sensor LVDS bus: locks to idle, parses header/data/footer, counts frames/errors.
// Optional SENSOR_CHK_CAPTURE_EN adds first-error capture outputs (first_err_cycle, first_err_byte).
module sensor_frame_checker #(
  parameter int PATTERN_WIDTH = 32,
  parameter int LVDS_WIDTH    = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LVDS_WIDTH-1:0]    lvds,
  input  logic [31:0]              cycles_per_frame,
  input  logic [7:0]               idle_0,
  input  logic [7:0]               idle_1,
  input  logic [31:0]              frame_header,
  input  logic                     clear,
  input  logic [PATTERN_WIDTH-1:0] EXPECT_TDATA,
  input  logic                     EXPECT_TVALID,
  output logic                     EXPECT_TREADY,
  output logic                     locked,
  output logic                     in_frame,
  output logic                     frame_done,
  output logic                     frame_ok,
  output logic [31:0]              frame_count,
  output logic [31:0]              error_count,
  output logic [3:0]               err_flags
`ifdef SENSOR_CHK_CAPTURE_EN
  ,
  output logic [31:0]              first_err_cycle,
  output logic [7:0]               first_err_byte
`endif
);

  typedef enum logic [2:0] {HUNT, EXP0, EXP1, HDR, DATA, FTR} state_t;

  localparam int EXT_REP = 64 / PATTERN_WIDTH;

  function automatic logic [LVDS_WIDTH-1:0] rep(input logic [7:0] b);
    return {(LVDS_WIDTH/8){b}};
  endfunction

  state_t                   state_q;
  logic [31:0]              cyc_q, cpf_q;
  logic [PATTERN_WIDTH-1:0] pat_q;
  logic                     noexp_q, hdr_bad_q, data_bad_q;
  logic                     done_q, ok_q;
  logic [31:0]              fcnt_q, ecnt_q;
  logic [3:0]               flags_q;

  logic [LVDS_WIDTH-1:0]    byte_num, exp_d;
  logic [63:0]              ext;
  logic [2:0]               vec_idx;
  logic [7:0]               vec_byte;
  logic                     is_idle0, is_idle1, is_hdr0;
  logic                     hdr_mis_d, data_mis_d, sync_err_d, noexp_set_d;
  logic                     last_d, frame_bad_d;

  always_comb begin
    byte_num = '0;
    for (int unsigned i = 0; i < LVDS_WIDTH/8; i++) byte_num[8*i +: 8] = 8'(i);
  end

  // vec[k] takes bytes of the 64-bit replicated pattern MSB-first
  assign ext      = {EXT_REP{pat_q}};
  assign vec_idx  = 3'd7 - cyc_q[4:2];
  assign vec_byte = ext[{vec_idx, 3'b000} +: 8];

  always_comb begin
    exp_d = '0;
    case (state_q)
      HDR: begin
        case (cyc_q)
          32'd1:   exp_d = rep(frame_header[15:8]);
          32'd2:   exp_d = rep(frame_header[23:16]);
          32'd3:   exp_d = rep(frame_header[31:24]);
          32'd11:  exp_d = byte_num;
          default: exp_d = '0;
        endcase
      end
      DATA:    exp_d = rep(vec_byte);
      default: exp_d = '0;
    endcase
  end

  assign is_idle0    = (lvds == rep(idle_0));
  assign is_idle1    = (lvds == rep(idle_1));
  assign is_hdr0     = (lvds == rep(frame_header[7:0]));
  assign hdr_mis_d   = (state_q == HDR) && (lvds != exp_d);
  assign data_mis_d  = ((state_q == DATA) && !noexp_q && (lvds != exp_d)) ||
                       ((state_q == FTR) && (lvds != exp_d));
  assign sync_err_d  = ((state_q == EXP0) && !is_hdr0 && !is_idle0) ||
                       ((state_q == EXP1) && !is_idle1);
  assign noexp_set_d = (state_q == EXP0) && is_hdr0 && !EXPECT_TVALID;
  assign last_d      = (state_q == FTR) && (cyc_q == cpf_q - 32'd1);
  assign frame_bad_d = hdr_bad_q | data_bad_q | hdr_mis_d | data_mis_d;

  assign EXPECT_TREADY = !reset && (state_q == EXP0) && is_hdr0 && EXPECT_TVALID;
  assign locked        = (state_q != HUNT);
  assign in_frame      = (state_q == HDR) || (state_q == DATA) || (state_q == FTR);
  assign frame_done    = done_q;
  assign frame_ok      = ok_q;
  assign frame_count   = fcnt_q;
  assign error_count   = ecnt_q;
  assign err_flags     = flags_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      cyc_q      <= '0;
      cpf_q      <= '0;
      pat_q      <= '0;
      noexp_q    <= 1'b0;
      hdr_bad_q  <= 1'b0;
      data_bad_q <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      fcnt_q     <= '0;
      ecnt_q     <= '0;
      flags_q    <= '0;
    end else begin
      done_q     <= last_d;
      ok_q       <= last_d && !frame_bad_d;
      hdr_bad_q  <= hdr_bad_q | hdr_mis_d;
      data_bad_q <= data_bad_q | data_mis_d;

      case (state_q)
        HUNT: if (is_idle1) state_q <= EXP0;
        EXP0: begin
          if (is_hdr0) begin
            state_q    <= HDR;
            cyc_q      <= 32'd1;
            cpf_q      <= cycles_per_frame;
            noexp_q    <= !EXPECT_TVALID;
            hdr_bad_q  <= 1'b0;
            data_bad_q <= 1'b0;
            if (EXPECT_TVALID) pat_q <= EXPECT_TDATA;
          end else if (is_idle0) begin
            state_q <= EXP1;
          end else begin
            state_q <= HUNT;
          end
        end
        EXP1: state_q <= is_idle1 ? EXP0 : HUNT;
        HDR: begin
          cyc_q <= cyc_q + 32'd1;
          if (cyc_q == 32'd15) state_q <= DATA;
        end
        DATA: begin
          cyc_q <= cyc_q + 32'd1;
          if (cyc_q == cpf_q - 32'd5) state_q <= FTR;
        end
        FTR: begin
          cyc_q <= cyc_q + 32'd1;
          if (last_d) state_q <= EXP0;
        end
        default: state_q <= HUNT;
      endcase

      // clear takes priority over both sticky flag updates and counter increments
      if (clear) begin
        flags_q <= '0;
        fcnt_q  <= '0;
        ecnt_q  <= '0;
      end else begin
        flags_q <= flags_q | {noexp_set_d, data_mis_d, hdr_mis_d, sync_err_d};
        if (last_d) begin
          if (fcnt_q != '1) fcnt_q <= fcnt_q + 32'd1;
          if (frame_bad_d && (ecnt_q != '1)) ecnt_q <= ecnt_q + 32'd1;
        end
      end
    end
  end

`ifdef SENSOR_CHK_CAPTURE_EN
  logic        cap_q;
  logic [31:0] cap_cyc_q;
  logic [7:0]  cap_byte_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cap_q      <= 1'b0;
      cap_cyc_q  <= '0;
      cap_byte_q <= '0;
    end else if (!cap_q && (hdr_mis_d || data_mis_d)) begin
      cap_q      <= 1'b1;
      cap_cyc_q  <= cyc_q;
      cap_byte_q <= lvds[7:0];
    end
  end

  assign first_err_cycle = cap_cyc_q;
  assign first_err_byte  = cap_byte_q;
`endif

endmodule

// File: tb/tb_sensor_frame_checker.sv
// Directed, table-driven bench for sensor_frame_checker (LVDS 512, pattern 32, cpf 64).
module tb_sensor_frame_checker;
  localparam int LW = 512;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] lvds;
  logic [31:0]   cycles_per_frame;
  logic [7:0]    idle_0, idle_1;
  logic [31:0]   frame_header;
  logic          clear;
  logic [PW-1:0] EXPECT_TDATA;
  logic          EXPECT_TVALID;
  logic          EXPECT_TREADY, locked, in_frame, frame_done, frame_ok;
  logic [31:0]   frame_count, error_count;
  logic [3:0]    err_flags;
`ifdef SENSOR_CHK_CAPTURE_EN
  logic [31:0]   first_err_cycle;
  logic [7:0]    first_err_byte;
`endif

  sensor_frame_checker #(.PATTERN_WIDTH(PW), .LVDS_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .lvds(lvds), .cycles_per_frame(cycles_per_frame),
    .idle_0(idle_0), .idle_1(idle_1), .frame_header(frame_header), .clear(clear),
    .EXPECT_TDATA(EXPECT_TDATA), .EXPECT_TVALID(EXPECT_TVALID), .EXPECT_TREADY(EXPECT_TREADY),
    .locked(locked), .in_frame(in_frame), .frame_done(frame_done), .frame_ok(frame_ok),
    .frame_count(frame_count), .error_count(error_count), .err_flags(err_flags)
`ifdef SENSOR_CHK_CAPTURE_EN
    , .first_err_cycle(first_err_cycle), .first_err_byte(first_err_byte)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int dones = 0;
  int cycle_no = 0;
  int first_done = 0;
  int last_done = 0;

  typedef struct {
    string      name;
    bit         clear_first;
    int         cpf;
    logic       tvalid;
    int         cc;
    int         cb;
    logic [7:0] cv;
    logic       exp_ok;
    logic [3:0] exp_flags;
    int         exp_fc;
    int         exp_ec;
    int         exp_pops;
    int         exp_cap_cyc;
    logic [7:0] exp_cap_byte;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rep8(input logic [7:0] b);
    logic [LW-1:0] r;
    for (int i = 0; i < LW/8; i++) r[8*i +: 8] = b;
    return r;
  endfunction

  // Reference frame content for header 0x44332211 and pattern 0x01020304
  function automatic logic [LW-1:0] gen(input int c, input int cpf);
    logic [7:0]    pb[4];
    logic [LW-1:0] r;
    pb = '{8'h01, 8'h02, 8'h03, 8'h04};
    r  = '0;
    if (c == 0) r = rep8(8'h11);
    else if (c == 1) r = rep8(8'h22);
    else if (c == 2) r = rep8(8'h33);
    else if (c == 3) r = rep8(8'h44);
    else if (c == 11) begin
      for (int i = 0; i < LW/8; i++) r[8*i +: 8] = 8'(i);
    end else if (c >= 16 && c < cpf - 4) r = rep8(pb[(c/4) % 4]);
    return r;
  endfunction

  task automatic send_word(input logic [LW-1:0] w);
    lvds = w;
    #2;
    if (EXPECT_TREADY === 1'b1) pops++;
    @(posedge clk);
    #1;
    cycle_no++;
    if (frame_done === 1'b1) begin
      dones++;
      if (dones == 1) first_done = cycle_no;
      last_done = cycle_no;
    end
  endtask

  task automatic lock_up(input bit clr);
    clear = clr;
    send_word(rep8(8'hA5));
    clear = 1'b0;
    send_word(rep8(8'h5A));
    for (int i = 0; i < 10; i++) begin
      send_word(rep8(8'hA5));
      send_word(rep8(8'h5A));
    end
  endtask

  task automatic send_frame(input int cpf, input int cc, input int cb, input logic [7:0] cv,
                            input int clear_at, input bit glitch);
    logic [LW-1:0] w;
    cycles_per_frame = cpf;
    for (int c = 0; c < cpf; c++) begin
      w = gen(c, cpf);
      if (c == cc) begin
        if (cb < 0) w = rep8(cv);
        else w[8*cb +: 8] = cv;
      end
      if (glitch && c == 5) cycles_per_frame = 24;
      if (glitch && c == 40) cycles_per_frame = cpf;
      clear = (c == clear_at);
      send_word(w);
      clear = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{"clean",        1'b0, 64, 1'b1, -1, -1, 8'h00, 1'b1, 4'b0000, 1, 0, 1,  0, 8'h00};
    vecs[1] = '{"data_c20",     1'b0, 64, 1'b1, 20, -1, 8'h03, 1'b0, 4'b0100, 2, 1, 1, 20, 8'h03};
    vecs[2] = '{"no_expect",    1'b1, 64, 1'b0, -1, -1, 8'h00, 1'b1, 4'b1000, 1, 0, 0,  0, 8'h00};
    vecs[3] = '{"noexp_skip",   1'b1, 64, 1'b0, 30, -1, 8'hFF, 1'b1, 4'b1000, 1, 0, 0,  0, 8'h00};
    vecs[4] = '{"hdr_c11_b5",   1'b1, 64, 1'b1, 11,  5, 8'h00, 1'b0, 4'b0010, 1, 1, 1, 11, 8'h00};
    vecs[5] = '{"hdr_c15",      1'b1, 64, 1'b1, 15,  0, 8'h77, 1'b0, 4'b0010, 1, 1, 1, 15, 8'h77};
    vecs[6] = '{"data_last",    1'b1, 64, 1'b1, 59, -1, 8'hFF, 1'b0, 4'b0100, 1, 1, 1, 59, 8'hFF};
    vecs[7] = '{"ftr_c62",      1'b1, 64, 1'b1, 62, 63, 8'h01, 1'b0, 4'b0100, 1, 1, 1, 62, 8'h00};
    vecs[8] = '{"cpf24_clean",  1'b1, 24, 1'b1, -1, -1, 8'h00, 1'b1, 4'b0000, 1, 0, 1,  0, 8'h00};
    vecs[9] = '{"cpf24_c19",    1'b1, 24, 1'b1, 19, -1, 8'h00, 1'b0, 4'b0100, 1, 1, 1, 19, 8'h00};

    reset = 1'b1;
    lvds = '0;
    cycles_per_frame = 32'd64;
    idle_0 = 8'hA5;
    idle_1 = 8'h5A;
    frame_header = 32'h44332211;
    clear = 1'b0;
    EXPECT_TDATA = 32'h01020304;
    EXPECT_TVALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_in_frame", in_frame, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_fcnt", frame_count, 0);
    chk("rst_ecnt", error_count, 0);
    chk("rst_flags", err_flags, 0);
    chk("rst_tready", EXPECT_TREADY, 0);
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      EXPECT_TVALID = vecs[v].tvalid;
      lock_up(vecs[v].clear_first);
      pops = 0;
      dones = 0;
      send_frame(vecs[v].cpf, vecs[v].cc, vecs[v].cb, vecs[v].cv, -1, 1'b0);
      chk({vecs[v].name, "_done"}, frame_done, 1);
      chk({vecs[v].name, "_ndone"}, dones, 1);
      chk({vecs[v].name, "_ok"}, frame_ok, vecs[v].exp_ok);
      chk({vecs[v].name, "_flags"}, err_flags, vecs[v].exp_flags);
      chk({vecs[v].name, "_fcnt"}, frame_count, vecs[v].exp_fc);
      chk({vecs[v].name, "_ecnt"}, error_count, vecs[v].exp_ec);
      chk({vecs[v].name, "_pops"}, pops, vecs[v].exp_pops);
`ifdef SENSOR_CHK_CAPTURE_EN
      chk({vecs[v].name, "_capcyc"}, first_err_cycle, vecs[v].exp_cap_cyc);
      chk({vecs[v].name, "_capbyte"}, first_err_byte, vecs[v].exp_cap_byte);
`endif
    end
    EXPECT_TVALID = 1'b1;

    // Sync loss on a corrupted idle_1, then relock
    lock_up(1'b1);
    dones = 0;
    send_word(rep8(8'hA5));
    send_word(rep8(8'h00));
    chk("sync_flag", err_flags, 4'b0001);
    chk("sync_unlocked", locked, 0);
    send_word(rep8(8'hA5));
    chk("sync_still_hunt", locked, 0);
    send_word(rep8(8'h5A));
    chk("sync_relock", locked, 1);
    chk("sync_no_done", dones, 0);
    send_word(rep8(8'hA5));
    send_word(rep8(8'h5A));
    send_frame(64, -1, -1, 8'h00, -1, 1'b0);
    chk("sync_frame_ok", frame_ok, 1);
    chk("sync_fcnt", frame_count, 1);
    chk("sync_flag_sticky", err_flags, 4'b0001);

    // Back-to-back frames, with cycles_per_frame disturbed mid-frame
    lock_up(1'b1);
    dones = 0;
    send_frame(64, -1, -1, 8'h00, -1, 1'b1);
    send_frame(64, -1, -1, 8'h00, -1, 1'b0);
    chk("b2b_ndone", dones, 2);
    chk("b2b_spacing", last_done - first_done, 64);
    chk("b2b_fcnt", frame_count, 2);
    chk("b2b_flags", err_flags, 0);

    // Reset mid-frame: no frame_done, back to HUNT
    lock_up(1'b0);
    dones = 0;
    for (int c = 0; c < 31; c++) send_word(gen(c, 64));
    chk("rmid_in_frame", in_frame, 1);
    reset = 1'b1;
    send_word(gen(31, 64));
    reset = 1'b0;
    chk("rmid_locked", locked, 0);
    chk("rmid_in_frame0", in_frame, 0);
    chk("rmid_fcnt", frame_count, 0);
    for (int c = 32; c < 64; c++) send_word(gen(c, 64));
    chk("rmid_no_done", dones, 0);
    chk("rmid_hunt", locked, 0);
    lock_up(1'b0);
    pops = 0;
    send_frame(64, -1, -1, 8'h00, -1, 1'b0);
    chk("rmid_after_fcnt", frame_count, 1);
    chk("rmid_after_pops", pops, 1);

    // Clear coincident with frame end: counters and flags stay zero
    lock_up(1'b1);
    dones = 0;
    send_frame(64, 20, -1, 8'h03, 63, 1'b0);
    chk("clr_done", dones, 1);
    chk("clr_ok", frame_ok, 0);
    chk("clr_fcnt", frame_count, 0);
    chk("clr_ecnt", error_count, 0);
    chk("clr_flags", err_flags, 0);
`ifdef SENSOR_CHK_CAPTURE_EN
    chk("clr_capcyc", first_err_cycle, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
